// File: rtl/fifo.sv
// Synchronous single-clock FIFO with first-word-fall-through read port.
// Optional occupancy output enabled by defining FIFO_COUNT_EN.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  empty,
  output logic                  full,
`ifdef FIFO_COUNT_EN
  output logic [ADDR_WIDTH:0]   count,
`endif
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic wr_ok, rd_ok;

  // A write while full is accepted only when a pop frees the head slot.
  assign rd_ok  = rd & ~empty;
  assign wr_ok  = wr & (~full | rd);
  assign wr_nxt = wr_ptr + 1'b1;
  assign rd_nxt = rd_ptr + 1'b1;
  assign r_data = mem[rd_ptr];

  // Storage is never cleared; reset only forgets it via the pointers.
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_nxt;
      if (rd_ok) rd_ptr <= rd_nxt;
      case ({wr_ok, rd_ok})
        2'b10: begin
          empty <= 1'b0;
          full  <= (wr_nxt == rd_ptr);
        end
        2'b01: begin
          full  <= 1'b0;
          empty <= (rd_nxt == wr_ptr);
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) count <= '0;
    else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: a queue-based reference model tracks contents,
// a negedge monitor compares flags and head word against it.
module tb_fifo;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset, rd, wr;
  logic [DW-1:0] w_data, r_data;
  logic empty, full;
`ifdef FIFO_COUNT_EN
  logic [AW:0] count;
`endif

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .w_data(w_data),
    .empty(empty), .full(full),
`ifdef FIFO_COUNT_EN
    .count(count),
`endif
    .r_data(r_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy rules applied to a plain queue.
  always @(posedge clk) begin
    if (!reset) begin
      exp_q.delete();
      chk_en <= 1'b1;
    end else begin
      int n;
      bit do_pop, do_push;
      n = exp_q.size();
      do_pop  = rd && n > 0;
      do_push = wr && (n < DEPTH || rd);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(w_data);
    end
  end

  // Monitor: away from the active edge, compare DUT view with the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("empty", empty, exp_q.size() == 0);
      chk("full", full, exp_q.size() == DEPTH);
`ifdef FIFO_COUNT_EN
      chk("count", count, exp_q.size());
`endif
      if (exp_q.size() > 0) chk("r_data", r_data, exp_q[0]);
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d);
    wr = w; rd = r; w_data = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; w_data = '0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);

    // Spaced writes then pops
    cyc(1, 0, 8'h11); cyc(0, 0, 0);
    cyc(1, 0, 8'h22); cyc(0, 0, 0);
    cyc(1, 0, 8'h33); cyc(0, 0, 0);
    chk("head0", r_data, 8'h11); cyc(0, 1, 0); cyc(0, 0, 0);
    chk("head1", r_data, 8'h22); cyc(0, 1, 0); cyc(0, 0, 0);
    chk("head2", r_data, 8'h33); cyc(0, 1, 0);
    chk("drain_empty", empty, 1);

    // Fill to full, overflow, drain, underflow
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, DW'(i));
    chk("fill_full", full, 1);
    cyc(1, 0, 8'hFF);
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_rd", r_data, i);
      cyc(0, 1, 0);
    end
    chk("fill_empty", empty, 1);
    cyc(0, 1, 0);
    cyc(1, 0, 8'hA5);
    chk("after_underflow", r_data, 8'hA5);
    cyc(0, 1, 0);

    // Wrap-around
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h90 + DW'(i));
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    cyc(1, 0, 8'h44); cyc(1, 0, 8'h55); cyc(1, 0, 8'h66);
    chk("wrap0", r_data, 8'h44); cyc(0, 1, 0);
    chk("wrap1", r_data, 8'h55); cyc(0, 1, 0);
    chk("wrap2", r_data, 8'h66);
    chk("wrap_nonempty", empty, 0);
    cyc(0, 1, 0);

    // Simultaneous rd&wr on full, then on empty
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'h80 + DW'(i));
    cyc(1, 1, 8'hEE);
    chk("rw_full_flag", full, 1);
    chk("rw_full_head", r_data, 8'h81);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0);
    chk("rw_drained", empty, 1);
    cyc(1, 1, 8'h3C);
    chk("rw_empty_flag", empty, 0);
    chk("rw_empty_head", r_data, 8'h3C);
    cyc(0, 1, 0);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'hC0 + DW'(i));
    reset = 1'b0;
    cyc(1, 1, 8'h77);
    reset = 1'b1;
    chk("midrst_empty", empty, 1);
    chk("midrst_full", full, 0);
`ifdef FIFO_COUNT_EN
    chk("midrst_count", count, 0);
`endif
    cyc(1, 0, 8'h5A);
    chk("midrst_data", r_data, 8'h5A);
    cyc(0, 1, 0);

    // Randomized traffic with biased fill/drain phases and rare resets
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 250) % 2 == 0) ? 70 : 30;
      reset = ($urandom_range(0, 299) != 0);
      cyc($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 20,
          DW'($urandom));
      reset = 1'b1;
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock FIFO buffer.
- Stores up to 2**ADDR_WIDTH words of DATA_WIDTH bits.
- Exposes empty/full status and a first-word-fall-through read port.
- Generic elastic buffer between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width in bits of each stored word.
- ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH (16 by default).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; 0 sampled at posedge clears the FIFO.
- rd  input  1  read/pop request; one word removed per cycle it is high and FIFO is not empty.
- wr  input  1  write/push request; w_data stored per cycle it is high and FIFO is not full.
- w_data  input  DATA_WIDTH  write data.
- empty  output  1  high when FIFO holds 0 words.
- full  output  1  high when FIFO holds 2**ADDR_WIDTH words.
- r_data  output  DATA_WIDTH  word at head of FIFO; valid while empty=0.

Behaviour:
- One clock (clk); reset is synchronous and active-low, named reset. reset=0 at a rising edge sets read pointer=0, write pointer=0, empty=1, full=0. Memory contents are not cleared.
- Storage is a register array of 2**ADDR_WIDTH x DATA_WIDTH, written on the rising edge.
- Read pointer and write pointer are ADDR_WIDTH bits wide and wrap from 2**ADDR_WIDTH-1 to 0.
- empty and full are registered status flags updated on the same edge as the pointers.
- r_data is combinational: r_data = mem[rd_ptr] (first-word fall-through).
  - The head word is visible the cycle after the write that made empty=0.
  - Asserting rd pops it at the next edge; r_data then shows the next word.
  - r_data is don't-care while empty=1.
- Per rising edge (reset high), by {wr, rd}:
  - 00: no change.
  - 10, not full: mem[wr_ptr] <= w_data; wr_ptr++; empty <= 0; full <= 1 if the incremented wr_ptr == rd_ptr.
  - 10, full: write ignored; no state change (overflow dropped silently).
  - 01, not empty: rd_ptr++; full <= 0; empty <= 1 if the incremented rd_ptr == wr_ptr.
  - 01, empty: read ignored; no state change.
  - 11, neither empty nor full: write and read both occur; both pointers advance; flags unchanged.
  - 11, empty: write only; empty <= 0. The read is ignored; no data bypass in the same cycle.
  - 11, full: read and write both occur; pointers advance; full stays 1. The new word occupies the freed slot.
- Latency: the written word appears on r_data one cycle after the write edge, if the FIFO was empty.
- Reset mid-operation discards all stored words in one cycle. Inputs are ignored during that cycle.

Optional Feature:
- Macro FIFO_COUNT_EN.
- When defined:
  - Adds output port count, ADDR_WIDTH+1 bits: number of words currently stored, 0..2**ADDR_WIDTH.
  - count is registered and reset to 0.
  - Accepted write only: count+1. Accepted read only: count-1. Both accepted, or neither: unchanged.
  - Invariants: count==0 iff empty; count==2**ADDR_WIDTH iff full.
- When undefined: no count port and no count logic; all other behaviour identical.

Test Plan:
- Reset held low 10 cycles, then released -> empty=1, full=0 (count=0 if enabled).
- Write 0x11, 0x22, 0x33, one per pulse with idle cycles between, then three single-cycle rd pulses:
  - Before each pop, r_data shows 0x11, then 0x22, then 0x33.
  - empty=1 after the third pop; full=0 throughout.
- Write 16 words 0x00..0x0F:
  - full=1 after the 16th.
  - A 17th write of 0xFF is ignored.
  - 16 reads return 0x00..0x0F in order; empty=1 at the end.
  - An extra rd while empty leaves the pointers unchanged, so a subsequent write of 0xA5 reads back 0xA5.
- Wrap-around: perform 3 writes and 3 reads, then write 0x44, 0x55, 0x66 and read two -> r_data shows 0x44, then 0x55, then 0x66; empty=0 with one word left.
- Simultaneous rd&wr:
  - On full: full stays 1 and the oldest word is replaced at the tail.
  - On empty: empty goes to 0 and r_data shows w_data.
- With 5 words stored, pull reset low for one cycle -> empty=1, full=0, count=0; the next write/read pair returns the newly written word.
